// File: rtl/updown_sequencer_if.sv
`timescale 1ns/1ps
// updown_sequencer_if: control, limit and counter-side signals of the up/down sequencer
interface updown_sequencer_if;
    logic       start;
    logic       stop;
    logic [3:0] lo_lim;
    logic [3:0] hi_lim;
    logic [3:0] cnt_in;
    logic       tick;
    logic       m;
    logic [3:0] cnt_q;
    logic       at_limit;
    logic       busy;
    logic       err;
    modport master (output start, stop, lo_lim, hi_lim, cnt_in, input tick, m, cnt_q, at_limit, busy, err);
    modport slave (input start, stop, lo_lim, hi_lim, cnt_in, output tick, m, cnt_q, at_limit, busy, err);
endinterface

// File: rtl/updown_sequencer.sv
`timescale 1ns/1ps
// updown_sequencer: ping-pongs a ripple up/down counter between limits, validating each step after a settle window
module updown_sequencer #(
    parameter int SETTLE = 2
) (
    input logic clk,
    input logic rst,
    updown_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_GUARD, S_BASE, S_TICK_HI, S_TICK_LO, S_SETTLE, S_CHECK, S_ERR} state_t;
    localparam logic [3:0] WAIT_LD = 4'(SETTLE - 1);
    state_t     r_state;
    logic [3:0] r_wait;
    logic [3:0] r_lo;
    logic [3:0] r_hi;
    logic [3:0] r_cnt_q;
    logic       r_tick;
    logic       r_m;
    logic       r_at_limit;
    logic       r_err;
    logic       r_stop;
    logic [3:0] w_exp;
    logic       w_start_ok;
    logic       w_busy;
    logic       w_stop;
    logic       w_turn;
    assign w_exp      = r_m ? r_cnt_q + 4'd1 : r_cnt_q - 4'd1;
    assign w_start_ok = bus.start && (bus.lo_lim < bus.hi_lim);
    assign w_busy     = (r_state != S_IDLE) && (r_state != S_ERR);
    assign w_stop     = r_stop || bus.stop;
    assign w_turn     = bus.cnt_in == (r_m ? r_hi : r_lo);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait     <= 4'd0;
            r_lo       <= 4'd0;
            r_hi       <= 4'd0;
            r_cnt_q    <= 4'd0;
            r_tick     <= 1'b0;
            r_m        <= 1'b1;
            r_at_limit <= 1'b0;
            r_err      <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_tick     <= 1'b0;
            r_at_limit <= 1'b0;
            if (w_busy && bus.stop) r_stop <= 1'b1;
            case (r_state)
                S_IDLE, S_ERR: if (w_start_ok) begin
                    r_lo    <= bus.lo_lim;
                    r_hi    <= bus.hi_lim;
                    r_err   <= 1'b0;
                    r_stop  <= 1'b0;
                    r_m     <= (bus.cnt_in < bus.hi_lim);
                    r_wait  <= WAIT_LD;
                    r_state <= S_GUARD;
                end
                S_GUARD: if (r_wait == 4'd0) r_state <= S_BASE; else r_wait <= r_wait - 4'd1;
                S_BASE: begin
                    r_cnt_q <= bus.cnt_in;
                    if (w_stop) begin
                        r_stop  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tick  <= 1'b1;
                        r_state <= S_TICK_HI;
                    end
                end
                S_TICK_HI: r_state <= S_TICK_LO;
                S_TICK_LO: begin
                    r_wait  <= WAIT_LD;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: if (r_wait == 4'd0) r_state <= S_CHECK; else r_wait <= r_wait - 4'd1;
                S_CHECK: if (bus.cnt_in != w_exp) begin
                    r_err   <= 1'b1;
                    r_state <= S_ERR;
                end else begin
                    r_cnt_q <= bus.cnt_in;
                    // a pending stop wins over a turn-around
                    if (w_stop) begin
                        r_stop  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_turn) begin
                        r_m        <= ~r_m;
                        r_at_limit <= 1'b1;
                        r_wait     <= WAIT_LD;
                        r_state    <= S_GUARD;
                    end else begin
                        r_tick  <= 1'b1;
                        r_state <= S_TICK_HI;
                    end
                end
            endcase
        end
    end
    assign bus.tick     = r_tick;
    assign bus.m        = r_m;
    assign bus.cnt_q    = r_cnt_q;
    assign bus.at_limit = r_at_limit;
    assign bus.busy     = w_busy;
    assign bus.err      = r_err;
endmodule
